equalizer_div_sdiv_28s_16s_16_seq: RTL and testbench

Iterative signed divider for the equalizer datapath. It takes the wide products and accumulations produced by the equalizer's pipelined 16x16 multipliers and divides them by a 16-bit channel-estimate term. It returns a 16-bit quotient and a remainder, truncating toward zero. It sits between the equalizer's multiply/accumulate stage and the sample output buffer. It uses a valid/ready handshake on both sides and a `ce` freeze input, matching the multiplier cores.

---
 rtl/equalizer_div_sdiv_28s_16s_16_seq_if.sv | 29 ++
 rtl/equalizer_div_sdiv_28s_16s_16_seq.sv | 166 ++++++++++++++++
 tb/tb_equalizer_div_sdiv_28s_16s_16_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/equalizer_div_sdiv_28s_16s_16_seq_if.sv
// Valid/ready bus of the iterative signed divider.
// The master side feeds dividend/divisor pairs and accepts results.
// The slave side is the divider itself.
interface equalizer_div_sdiv_28s_16s_16_seq_if #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         div_zero;
  logic                         ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/equalizer_div_sdiv_28s_16s_16_seq.sv
// Iterative restoring signed divider: one quotient bit per enabled edge.
// Quotient and remainder truncate toward zero, and the remainder sign follows the dividend.
// Optional macro EQUALIZER_DIV_SAT_EN: clamp an out-of-range quotient and flag ovf.
// Without EQUALIZER_DIV_SAT_EN the quotient wraps and ovf stays 0.
module equalizer_div_sdiv_28s_16s_16_seq #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  equalizer_div_sdiv_28s_16s_16_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int QF_W  = DIVIDEND_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        in_ready_r;
  logic                        out_valid_r;
  logic                        div_zero_r;
  logic                        ovf_r;
  logic signed [QUOT_W-1:0]    quot_r;
  logic signed [DIVISOR_W-1:0] rem_r;
  logic                        sign_n;
  logic                        sign_d;

  // Datapath state: magnitudes and the running partial remainder.
  logic [DIVIDEND_W-1:0]       dvd_mag;
  logic [DIVIDEND_W-1:0]       quo_mag;
  logic [DIVISOR_W-1:0]        dvs_mag;
  logic [DIVISOR_W:0]          prem;

  logic                        accept;
  logic [DIVIDEND_W-1:0]       dividend_abs;
  logic [DIVISOR_W-1:0]        divisor_abs;
  logic [DIVISOR_W+1:0]        shifted;
  logic [DIVISOR_W+1:0]        trial;
  logic                        take;
  logic signed [QF_W-1:0]      quot_mag_s;
  logic signed [QF_W-1:0]      quot_full;
  logic [DIVISOR_W-1:0]        rem_mag;
  logic [DIVISOR_W-1:0]        rem_u;

  // Map the full signed quotient onto QUOT_W bits; the MSB of the result is the overflow flag.
  function automatic logic [QUOT_W:0] range_quot(input logic signed [QF_W-1:0] q);
    logic signed [QF_W-1:0] qmax;
    logic signed [QF_W-1:0] qmin;
    qmax = {{(QF_W-QUOT_W+1){1'b0}}, {(QUOT_W-1){1'b1}}};
    qmin = ~qmax;
`ifdef EQUALIZER_DIV_SAT_EN
    if (q > qmax)
      return {1'b1, 1'b0, {(QUOT_W-1){1'b1}}};
    else if (q < qmin)
      return {1'b1, 1'b1, {(QUOT_W-1){1'b0}}};
    else
      return {1'b0, q[QUOT_W-1:0]};
`else
    if ((q > qmax) || (q < qmin))
      return {1'b0, q[QUOT_W-1:0]};
    else
      return {1'b0, q[QUOT_W-1:0]};
`endif
  endfunction

  assign accept = (state == IDLE) && in_ready_r && bus.in_valid;

  // The unsigned magnitude is one bit wider in value range, so |min negative| stays exact.
  assign dividend_abs = bus.dividend[DIVIDEND_W-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign divisor_abs  = bus.divisor[DIVISOR_W-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;

  // Restoring step: bring in the next dividend bit, then trial-subtract |divisor|.
  assign shifted = {prem, dvd_mag[DIVIDEND_W-1]};
  assign trial   = shifted - {2'b00, dvs_mag};
  assign take    = ~trial[DIVISOR_W+1];

  assign quot_mag_s = $signed({1'b0, quo_mag});
  assign quot_full  = (sign_n ^ sign_d) ? -quot_mag_s : quot_mag_s;
  assign rem_mag    = prem[DIVISOR_W-1:0];
  assign rem_u      = sign_n ? (~rem_mag + 1'b1) : rem_mag;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = div_zero_r;
  assign bus.ovf       = ovf_r;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      div_zero_r  <= 1'b0;
      ovf_r       <= 1'b0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_r <= 1'b0;
            sign_n     <= bus.dividend[DIVIDEND_W-1];
            sign_d     <= bus.divisor[DIVISOR_W-1];
            cnt        <= CNT_W'(DIVIDEND_W - 1);
            state      <= CALC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          if (dvs_mag == '0) begin
            div_zero_r <= 1'b1;
            ovf_r      <= 1'b0;
            rem_r      <= '0;
            quot_r     <= sign_n ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}};
          end else begin
            div_zero_r      <= 1'b0;
            {ovf_r, quot_r} <= range_quot(quot_full);
            rem_r           <= rem_u;
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: load magnitudes on acceptance, shift/subtract once per CALC edge.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (accept) begin
        dvd_mag <= dividend_abs;
        dvs_mag <= divisor_abs;
        prem    <= '0;
        quo_mag <= '0;
      end else if (state == CALC) begin
        dvd_mag <= {dvd_mag[DIVIDEND_W-2:0], 1'b0};
        quo_mag <= {quo_mag[DIVIDEND_W-2:0], take};
        prem    <= take ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
      end
    end
  end

endmodule

// File: tb/tb_equalizer_div_sdiv_28s_16s_16_seq.sv
// Testbench for the iterative signed divider.
// It runs directed vectors, randomized operations against an arithmetic reference, and handshake/stall/reset sequences.
module tb_equalizer_div_sdiv_28s_16s_16_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  equalizer_div_sdiv_28s_16s_16_seq_if #(.DIVIDEND_W(28), .DIVISOR_W(16), .QUOT_W(16)) bus();

  equalizer_div_sdiv_28s_16s_16_seq #(.DIVIDEND_W(28), .DIVISOR_W(16), .QUOT_W(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce(ce),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     a;
    longint     b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division truncates toward zero; % takes the dividend's sign.
  task automatic model(input longint a, input longint b, output logic [15:0] q,
                       output logic [15:0] r, output logic dz, output logic ov);
    longint qf;
    longint rf;
    if (b == 0) begin
      dz = 1'b1; r = 16'h0; ov = 1'b0;
      q  = (a >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      dz = 1'b0;
      qf = a / b;
      rf = a % b;
      r  = rf[15:0];
`ifdef EQUALIZER_DIV_SAT_EN
      if (qf > 32767) begin q = 16'h7FFF; ov = 1'b1; end
      else if (qf < -32768) begin q = 16'h8000; ov = 1'b1; end
      else begin q = qf[15:0]; ov = 1'b0; end
`else
      q  = qf[15:0];
      ov = 1'b0;
`endif
    end
  endtask

  // Offer one pair, then count edges after acceptance until out_valid (optionally stalling ce).
  task automatic issue(input logic signed [27:0] a, input logic signed [15:0] b,
                       input int nstall, output int lat);
    int w;
    int stalls;
    w = 0; stalls = 0; lat = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      lat = -1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (1) begin
      lat++;
      ce = !(stalls < nstall && (lat % 3) == 0);
      if (!ce) stalls++;
      @(posedge clk);
      #1;
      if (bus.out_valid || lat >= 200) break;
      @(negedge clk);
    end
    ce = 1'b1;
  endtask

  task automatic retire();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_model(input string tag, input logic signed [27:0] a,
                           input logic signed [15:0] b, input int nstall);
    int lat;
    logic [15:0] eq, er;
    logic edz, eov;
    issue(a, b, nstall, lat);
    model(longint'(a), longint'(b), eq, er, edz, eov);
    check({tag, "_q"}, {bus.quotient}, {16'h0, eq});
    check({tag, "_r"}, {bus.remainder}, {16'h0, er});
    check({tag, "_dz"}, {31'h0, bus.div_zero}, {31'h0, edz});
    check({tag, "_ovf"}, {31'h0, bus.ovf}, {31'h0, eov});
    check({tag, "_lat"}, lat, 29 + nstall);
    retire();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'h0);
    check({tag, "_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
    check({tag, "_quotient"}, {bus.quotient}, 32'h0);
    check({tag, "_remainder"}, {bus.remainder}, 32'h0);
    check({tag, "_div_zero"}, {31'h0, bus.div_zero}, 32'h0);
    check({tag, "_ovf"}, {31'h0, bus.ovf}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    int n_edge;
    int acc1;
    int acc2;
    logic [15:0] q0, r0;
    logic dz0, ov0;
    logic signed [27:0] ra;
    logic signed [15:0] rb;
    int t;

    vt[0]  = '{1000, 7, 16'd142, 16'd6, 1'b0, 1'b0};
    vt[1]  = '{-1000, 7, 16'hFF72, 16'hFFFA, 1'b0, 1'b0};
    vt[2]  = '{1000, -7, 16'hFF72, 16'd6, 1'b0, 1'b0};
`ifdef EQUALIZER_DIV_SAT_EN
    vt[3]  = '{-134217728, -1, 16'h7FFF, 16'h0, 1'b0, 1'b1};
    vt[4]  = '{1048576, 1, 16'h7FFF, 16'h0, 1'b0, 1'b1};
`else
    vt[3]  = '{-134217728, -1, 16'h0000, 16'h0, 1'b0, 1'b0};
    vt[4]  = '{1048576, 1, 16'h0000, 16'h0, 1'b0, 1'b0};
`endif
    vt[5]  = '{32767, 1, 16'h7FFF, 16'h0, 1'b0, 1'b0};
    vt[6]  = '{500, 0, 16'h7FFF, 16'h0, 1'b1, 1'b0};
    vt[7]  = '{-500, 0, 16'h8000, 16'h0, 1'b1, 1'b0};
    vt[8]  = '{0, 5, 16'h0, 16'h0, 1'b0, 1'b0};
    vt[9]  = '{35, 5, 16'd7, 16'h0, 1'b0, 1'b0};
    vt[10] = '{-32768, 1, 16'h8000, 16'h0, 1'b0, 1'b0};
    vt[11] = '{100000, -32768, 16'hFFFD, 16'h06A0, 1'b0, 1'b0};
    vt[12] = '{134217727, 32767, 16'h1000, 16'h0FFF, 1'b0, 1'b0};
    vt[13] = '{0, 0, 16'h7FFF, 16'h0, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0;   bus.divisor = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_idle_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      issue(28'(vt[i].a), 16'(vt[i].b), 0, lat);
      check($sformatf("vec%0d_q", i), {bus.quotient}, {16'h0, vt[i].q});
      check($sformatf("vec%0d_r", i), {bus.remainder}, {16'h0, vt[i].r});
      check($sformatf("vec%0d_dz", i), {31'h0, bus.div_zero}, {31'h0, vt[i].dz});
      check($sformatf("vec%0d_ovf", i), {31'h0, bus.ovf}, {31'h0, vt[i].ov});
      check($sformatf("vec%0d_lat", i), lat, 29);
      retire();
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: ra = 28'($urandom);
        1: begin t = int'($urandom_range(0, 80000)) - 40000; ra = 28'(t); end
        default: begin t = int'($urandom_range(0, 2000000)) - 1000000; ra = 28'(t); end
      endcase
      case ($urandom_range(0, 9))
        0: rb = 16'sd0;
        1, 2, 3: begin t = int'($urandom_range(1, 20)); rb = 16'($urandom_range(0, 1) ? -t : t); end
        default: rb = 16'($urandom);
      endcase
      run_model($sformatf("rnd%0d", i), ra, rb, 0);
    end

    // Backpressure: result and handshake outputs frozen while out_ready is low
    issue(28'sd1000, 16'sd7, 0, lat);
    q0 = bus.quotient; r0 = bus.remainder; dz0 = bus.div_zero; ov0 = bus.ovf;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.quotient !== q0 || bus.remainder !== r0 ||
          bus.div_zero !== dz0 || bus.ovf !== ov0) bad++;
    end
    check("bp_unstable_cycles", bad, 0);
    check("bp_quotient", {16'h0, q0}, 32'd142);
    check("bp_remainder", {16'h0, r0}, 32'd6);
    retire();

    // ce toggled during CALC stretches latency only
    run_model("stall", -28'sd123456, 16'sd321, 5);

    // ce low in DONE ignores out_ready
    issue(-28'sd1000, 16'sd7, 0, lat);
    @(negedge clk);
    ce = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("done_ce0_hold", {31'h0, bus.out_valid}, 32'h1);
    @(negedge clk);
    ce = 1'b1;
    @(posedge clk); #1;
    check("done_release_valid", {31'h0, bus.out_valid}, 32'h0);
    check("done_release_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Back-to-back acceptances with out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 28'sd1000;
    bus.divisor   = 16'sd7;
    n_edge = 0; acc1 = -1; acc2 = -1;
    while (acc2 < 0 && n_edge < 150) begin
      t = (bus.in_ready && bus.in_valid) ? 1 : 0;
      @(posedge clk);
      n_edge++;
      if (t == 1) begin
        if (acc1 < 0) acc1 = n_edge;
        else acc2 = n_edge;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("accept_spacing", acc2 - acc1, 31);
    repeat (40) @(negedge clk);
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-CALC discards the operation
    issue(28'sd1000, 16'sd7, 0, lat);
    retire();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 28'sd2000;
    bus.divisor  = 16'sd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("post_reset_no_valid", {31'h0, bus.out_valid}, 32'h0);
    issue(28'sd35, 16'sd5, 0, lat);
    check("post_reset_q", {bus.quotient}, 32'd7);
    check("post_reset_r", {bus.remainder}, 32'd0);
    check("post_reset_lat", lat, 29);
    retire();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
